// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one registered 4:1 mux among four requesters.
// Define MUX41_ARB_FIXED_PRI_EN for fixed priority i0 > i1 > i2 > i3 with holder exclusion on hold expiry.
module mux41_rr_arbiter #(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  input  logic [DATA_W-1:0] i2,
  input  logic [DATA_W-1:0] i3,
  output logic [3:0]        gnt,
  output logic              s1,
  output logic              s0,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  output logic              busy
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state;
  logic [1:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [1:0]        cur;
  logic [3:0]        cur_oh;
  logic              held_max;
  logic              release_c;
  logic [1:0]        arb_ptr;
  logic [3:0]        arb_req;
  logic              win_found;
  logic [1:0]        win_idx;
  logic [DATA_W-1:0] sel_data;

  assign cur       = {s1, s0};
  assign cur_oh    = 4'b0001 << cur;
  assign held_max  = (hold_cnt == HOLD_W'(MAX_HOLD));
  assign release_c = !req[cur] || (held_max && (|(req & ~cur_oh)));

  // Arbitration inputs: idle uses the stored pointer, a release rotates past the holder.
  always_comb begin
    arb_ptr = ptr;
    arb_req = req;
    if (state == GRANT) begin
`ifdef MUX41_ARB_FIXED_PRI_EN
      arb_ptr = 2'd0;
      if (req[cur]) arb_req = req & ~cur_oh;
`else
      arb_ptr = cur + 2'd1;
`endif
    end
  end

  // First asserted request searching from arb_ptr upward, mod 4.
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = arb_ptr + 2'(k);
      if (arb_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    sel_data = i0;
    case (cur)
      2'd0: sel_data = i0;
      2'd1: sel_data = i1;
      2'd2: sel_data = i2;
      2'd3: sel_data = i3;
      default: sel_data = i0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
      s1       <= 1'b0;
      s0       <= 1'b0;
      out      <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Datapath lags the grant by one cycle; out holds once the grant ends.
      if (state == GRANT) begin
        out   <= sel_data;
        valid <= 1'b1;
      end else begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            busy     <= 1'b1;
            gnt      <= 4'b0001 << win_idx;
            {s1, s0} <= win_idx;
            hold_cnt <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (release_c) begin
`ifndef MUX41_ARB_FIXED_PRI_EN
            ptr <= cur + 2'd1;
`endif
            if (win_found) begin
              gnt      <= 4'b0001 << win_idx;
              {s1, s0} <= win_idx;
              hold_cnt <= HOLD_W'(1);
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              gnt      <= 4'b0000;
              hold_cnt <= '0;
            end
          end else if (!held_max) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Scoreboard bench for mux41_rr_arbiter: random and directed request patterns checked
// against a cycle-level reference model of the arbitration rules.
module tb_mux41_rr_arbiter;

  localparam int unsigned DW = 4;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] i0, i1, i2, i3;
  logic [3:0]    gnt;
  logic          s1, s0, valid, busy;
  logic [DW-1:0] out;

  mux41_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .s1(s1), .s0(s0), .out(out), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic          valid;
    logic [DW-1:0] out;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: owner index (-1 when nobody holds the link), pointer, hold length.
  int            m_owner = -1;
  int            m_ptr = 0;
  int            m_hold = 0;
  int            m_sel = 0;
  logic [DW-1:0] m_out = '0;
  logic          m_valid = 1'b0;

  function automatic int arb(input logic [3:0] r, input int p, input int excl);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (p + k) % 4;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] dat(input int k);
    case (k)
      0: return i0;
      1: return i1;
      2: return i2;
      default: return i3;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_out = '0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic          nv;
    logic [DW-1:0] no;
    int            w, p, ex;
    bit            drop, expire, others;
    nv = (m_owner >= 0);
    no = nv ? dat(m_owner) : m_out;
    if (m_owner < 0) begin
      w = arb(r, m_ptr, -1);
      if (w >= 0) begin m_owner = w; m_hold = 1; m_sel = w; end
    end else begin
      others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
      drop   = !r[m_owner];
      expire = (m_hold == MH) && others;
      if (drop || expire) begin
`ifdef MUX41_ARB_FIXED_PRI_EN
        p  = 0;
        ex = drop ? -1 : m_owner;
`else
        m_ptr = (m_owner + 1) % 4;
        p  = m_ptr;
        ex = -1;
`endif
        w = arb(r, p, ex);
        if (w >= 0) begin m_owner = w; m_hold = 1; m_sel = w; end
        else m_owner = -1;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
    m_valid = nv;
    m_out   = no;
  endtask

  task automatic push_expect();
    exp_t e;
    e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.sel   = 2'(m_sel);
    e.busy  = (m_owner >= 0);
    e.valid = m_valid;
    e.out   = m_out;
    q.push_back(e);
  endtask

  // One stimulus cycle: drive at negedge, predict the next posedge's registered outputs.
  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    req = r;
    i0 = DW'($urandom); i1 = DW'($urandom); i2 = DW'($urandom); i3 = DW'($urandom);
    model_step(r);
    push_expect();
  endtask

  task automatic check_reset(input string name);
    tests++;
    if (gnt !== 4'b0000 || s1 !== 1'b0 || s0 !== 1'b0 || out !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: gnt=%b s=%b%b out=%h valid=%b busy=%b, required all zero",
               name, gnt, s1, s0, out, valid, busy);
    end
  endtask

  // Asynchronous reset in mid-cycle, then release with req idle so the unmodelled edge is a no-op.
  task automatic mid_reset(input string name);
    @(posedge clk);
    #3;
    req = 4'($urandom);
    rst_n = 1'b0;
    #1;
    check_reset(name);
    model_reset();
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs with the queued prediction after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (gnt !== e.gnt || {s1, s0} !== e.sel || busy !== e.busy ||
            valid !== e.valid || out !== e.out) begin
          fails++;
          $display("FAIL cycle%0d: gnt=%b s=%b busy=%b valid=%b out=%h, required gnt=%b s=%b busy=%b valid=%b out=%h",
                   cyc, gnt, {s1, s0}, busy, valid, out, e.gnt, e.sel, e.busy, e.valid, e.out);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b1;
    req = 4'($urandom);
    i0 = DW'($urandom); i1 = DW'($urandom); i2 = DW'($urandom); i3 = DW'($urandom);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("reset_immediate");
    repeat (3) @(negedge clk) req = 4'($urandom);
    #1;
    check_reset("reset_held");
    model_reset();
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, then idle.
    repeat (4) cycle(4'b0001);
    repeat (2) cycle(4'b0000);
    // All requesting: rotation with full-length holds.
    repeat (45) cycle(4'b1111);
    repeat (2) cycle(4'b0000);
    // Holder 3 drops while requester 1 arrives on the same cycle.
    repeat (3) cycle(4'b1000);
    repeat (4) cycle(4'b0010);
    cycle(4'b0000);
    // Lone requester past hold saturation, then drop.
    repeat (20) cycle(4'b0100);
    repeat (3) cycle(4'b0000);
    // Reset mid-grant, then everyone requests.
    repeat (3) cycle(4'b0100);
    mid_reset("reset_mid_grant");
    repeat (20) cycle(4'b1111);

    // Random sticky request patterns.
    r = 4'($urandom);
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
      if ($urandom_range(0, 39) == 0) r = 4'($urandom);
      if (n == 350) mid_reset("reset_random");
      cycle(r);
    end

    @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d predictions left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 mux datapath among four requesters.
- Grants one requester at a time and drives the mux select lines s1/s0 from the grant.
- Registers the selected data onto a single output with a valid flag.
- Sits between four producer blocks and one shared consumer link. Each grant lasts a bounded number of cycles.

Parameters:
- DATA_W, 1: width of each data input and of out.
- MAX_HOLD, 8: maximum cycles per grant while others wait. Legal range >= 1. Hold counter width is clog2(MAX_HOLD+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit k belongs to input ik. Held high while the requester wants the link.
- i0  input  DATA_W  requester 0 data.
- i1  input  DATA_W  requester 1 data.
- i2  input  DATA_W  requester 2 data.
- i3  input  DATA_W  requester 3 data.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- s1  output  1  mux select MSB, registered; {s1,s0} = granted index.
- s0  output  1  mux select LSB, registered.
- out  output  DATA_W  registered mux output.
- valid  output  1  out carries granted data this cycle.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset, asynchronous on rst_n=0, clears everything regardless of state:
  - gnt=0000, s1=0, s0=0, out=0, valid=0, busy=0.
  - State=IDLE, round-robin pointer ptr=0, hold_cnt=0.
  - Deassertion is a normal synchronous release; first arbitration happens on the first clk edge with rst_n=1.
- Arbitration order: search ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first asserted req wins.
- IDLE state:
  - If req==0000, stay in IDLE; gnt=0000; s1/s0 hold their last value.
  - If any req is set, the next edge enters GRANT, sets gnt one-hot and {s1,s0} to the index, and loads hold_cnt=1. Latency from req to gnt is 1 cycle.
- GRANT state:
  - Each cycle, out <= i[{s1,s0}] and valid <= 1. out/valid lag gnt by exactly 1 cycle.
  - After the grant ends, valid=0 on the following cycle; out holds its last value.
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Changes on non-granted req bits are ignored until a release.
- Release condition: the granted req bit is 0, OR (hold_cnt==MAX_HOLD AND any other req bit is 1).
- On release in the same edge:
  - ptr <= granted index + 1 mod 4.
  - Arbitrate with the new ptr. The released requester's bit counts only if still asserted, and it is then lowest priority.
  - If a winner exists, switch gnt/s1/s0 directly with no idle bubble and reload hold_cnt=1.
  - Otherwise go to IDLE with gnt=0000.
- Hold expiry with no other requester: the grant stays, hold_cnt stays at MAX_HOLD, and there is no release.
- Simultaneous drop of the granted req and a new req elsewhere: the switch happens on that edge, and the new gnt is visible the next cycle.
- gnt is always zero or one-hot, and {s1,s0} always equals the gnt index while busy=1.

Optional Feature:
- MUX41_ARB_FIXED_PRI_EN defined:
  - ptr is held at 0 permanently, giving priority i0 > i1 > i2 > i3.
  - On a hold-expiry release, the current holder is excluded from that single arbitration decision. This prevents starvation of the next-highest requester only.
- Undefined: round-robin as specified above.

Test Plan:
1. rst_n=0 with random req/data -> gnt=0000, s1=s0=0, out=0, valid=0, busy=0 immediately, without waiting for a clk edge.
2. After reset, req=0001, i0=1 -> edge1: gnt=0001, {s1,s0}=00, busy=1; edge2: valid=1, out=1.
3. req=1111 constant, MAX_HOLD=8 -> gnt sequence 0001, 0010, 0100, 1000, 0001, each exactly 8 cycles, no zero-gnt cycle between.
4. Holder 1000 drops req[3] while req=0010 arrives the same cycle -> next edge gnt=0010, {s1,s0}=01; valid stays 1 across the switch.
5. req=0100 alone for 20 cycles -> gnt=0100 all 20 cycles, hold_cnt saturates at 8; dropping req -> next edge gnt=0000, valid=0 one cycle later.
6. rst_n pulsed low mid-grant of 0100, then req=1111 -> immediate clear; first grant after reset is 0001. With MUX41_ARB_FIXED_PRI_EN and req=1111: grants alternate 0001 and 0010, 8 cycles each.
